// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RV32I control FSM
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
// and writeback states, driving every datapath enable of a multi-cycle core,
// including the PC write enable and next-PC select. Raises a sticky halt on
// the terminating ECALL.
//
// Optional feature macro: MC_PERF_CNT_EN (adds cycle_count / instr_count).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   opcode      IR[6:0], stable from decode onward
//   bcond       ALU branch-condition result
//   halt_cond   1 when x17 == 10
//   mem_ready   memory access completes this cycle
//   pc_update   PC write enable
//   pc_source   next PC: 0 = live ALU result, 1 = ALUOut register
//   i_or_d      memory address: 0 = PC, 1 = ALUOut
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    IR load enable
//   reg_write   register-file write enable
//   wb_sel      writeback data: 00 = ALUOut, 01 = MDR, 10 = live ALU result
//   alu_src_a   ALU A: 0 = PC, 1 = register A
//   alu_src_b   ALU B: 00 = register B, 01 = constant 4, 10 = immediate
//   alu_op      00 = add, 01 = branch compare, 10 = funct-decoded
//   is_halted   core halted (sticky until reset)
//   cycle_count (MC_PERF_CNT_EN) cycles spent while not halted
//   instr_count (MC_PERF_CNT_EN) retired instructions

module mc_control_unit #(
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             bcond,
  input  logic             halt_cond,
  input  logic             mem_ready,
  output logic             pc_update,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instr_count
`endif
);

  localparam logic [OPC_W-1:0] OPC_R     = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OPC_I     = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OPC_BR    = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OPC_JAL   = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OPC_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OPC_SYS   = OPC_W'(7'b1110011);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_LD   = 4'd6,
    S_MEM_WR  = 4'd7,
    S_EX_BR   = 4'd8,
    S_PC_INC  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR1   = 4'd11,
    S_JALR2   = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  state_t state, state_n;

  // Ungated versions of the enables that reset must force low.
  logic pc_update_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c, halted_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_update_c = 1'b0;
    pc_source   = 1'b0;
    i_or_d      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    wb_sel      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    halted_c    = 1'b0;

    case (state)
      S_IF: begin
        mem_read_c = 1'b1;
        ir_write_c = mem_ready;
        if (mem_ready) state_n = S_ID;
      end

      S_ID: begin
        // Branch/JAL target PC+imm is precomputed here and lands in ALUOut.
        alu_src_b = 2'b10;
        case (opcode)
          OPC_R, OPC_I:        state_n = S_EX_R;
          OPC_LOAD, OPC_STORE: state_n = S_EX_ADDR;
          OPC_BR:              state_n = S_EX_BR;
          OPC_JAL:             state_n = S_JAL;
          OPC_JALR:            state_n = S_JALR1;
          OPC_SYS:             state_n = halt_cond ? S_HALT : S_PC_INC;
          default:             state_n = S_PC_INC;
        endcase
      end

      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_src_b = (opcode == OPC_R) ? 2'b00 : 2'b10;
        state_n   = S_WB_R;
      end

      S_WB_R, S_WB_LD: begin
        reg_write_c = 1'b1;
        wb_sel      = (state == S_WB_LD) ? 2'b01 : 2'b00;
        alu_src_b   = 2'b01;
        pc_update_c = 1'b1;
        state_n     = S_IF;
      end

      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_n   = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) state_n = S_WB_LD;
      end

      S_MEM_WR: begin
        // The store retires in the cycle memory accepts it, so PC+4 is
        // written straight from the live ALU result.
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        alu_src_b   = 2'b01;
        pc_update_c = mem_ready;
        if (mem_ready) state_n = S_IF;
      end

      S_EX_BR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        if (bcond) begin
          pc_source   = 1'b1;
          pc_update_c = 1'b1;
          state_n     = S_IF;
        end else begin
          state_n = S_PC_INC;
        end
      end

      S_PC_INC: begin
        alu_src_b   = 2'b01;
        pc_update_c = 1'b1;
        state_n     = S_IF;
      end

      S_JAL: begin
        alu_src_b   = 2'b01;
        reg_write_c = 1'b1;
        wb_sel      = 2'b10;
        pc_source   = 1'b1;
        pc_update_c = 1'b1;
        state_n     = S_IF;
      end

      S_JALR1: begin
        // Link first; register A was latched in ID so rd == rs1 is safe.
        alu_src_b   = 2'b01;
        reg_write_c = 1'b1;
        wb_sel      = 2'b10;
        state_n     = S_JALR2;
      end

      S_JALR2: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        pc_update_c = 1'b1;
        state_n     = S_IF;
      end

      S_HALT: begin
        halted_c = 1'b1;
        state_n  = S_HALT;
      end

      default: begin
        state_n = S_IF;
      end
    endcase
  end

  // Reset is asynchronous, so the side-effecting enables are masked
  // combinationally to abort any write in the cycle reset arrives.
  assign pc_update = pc_update_c & reset;
  assign mem_read  = mem_read_c  & reset;
  assign mem_write = mem_write_c & reset;
  assign ir_write  = ir_write_c  & reset;
  assign reg_write = reg_write_c & reset;
  assign is_halted = halted_c    & reset;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else if (state != S_HALT) begin
      cycle_count <= cycle_count + 32'd1;
      if (pc_update_c) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit

module tb_mc_control_unit;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       bcond = 1'b0;
  logic       halt_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_update, pc_source, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, is_halted;
  logic [1:0] wb_sel, alu_src_b, alu_op;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .halt_cond(halt_cond), .mem_ready(mem_ready),
    .pc_update(pc_update), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted)
`ifdef MC_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  // Expected per-instruction observables, summarised at retire (or halt).
  typedef struct {
    int cycles;  // cycles from fetch start through the retiring cycle
    int halt;
    int pcsrc;   // pc_source at retire
    int asa;     // alu_src_a at retire
    int rwret;   // reg_write in the retiring cycle
    int nrw;     // register-write cycles
    int wb;      // wb_sel during the register write
    int nrd;     // data-read cycles (mem_read with i_or_d=1)
    int nwr;     // write-request cycles
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   retired = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: instruction class -> cycle cost and visible effects.
  function automatic exp_t model(input logic [6:0] opc, input bit bc, input bit hc,
                                 input int wif, input int wmem);
    exp_t e = '{default: 0};
    e.cycles = wif;
    case (opc)
      OP_R, OP_I: begin e.cycles += 4; e.nrw = 1; e.rwret = 1; e.wb = 0; end
      OP_LD:      begin e.cycles += 5 + wmem; e.nrw = 1; e.rwret = 1; e.wb = 1; e.nrd = 1 + wmem; end
      OP_ST:      begin e.cycles += 4 + wmem; e.nwr = 1 + wmem; end
      OP_BR:      if (bc) begin e.cycles += 3; e.pcsrc = 1; e.asa = 1; end
                  else e.cycles += 4;
      OP_JAL:     begin e.cycles += 3; e.nrw = 1; e.rwret = 1; e.wb = 2; e.pcsrc = 1; end
      OP_JALR:    begin e.cycles += 4; e.nrw = 1; e.wb = 2; e.asa = 1; end
      OP_SYS:     begin e.cycles += 3; e.halt = hc ? 1 : 0; end
      default:    e.cycles += 3;
    endcase
    return e;
  endfunction

  // Monitor: accumulates what the DUT shows each cycle and checks a
  // scoreboard entry whenever an instruction retires or the core halts.
  initial begin : monitor
    int cyc, nir, nrw, wb, nrd, nwr;
    bit halted;
    exp_t e;
    cyc = 0; nir = 0; nrw = 0; wb = 0; nrd = 0; nwr = 0; halted = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("reset_enables_low",
            int'({pc_update, ir_write, reg_write, mem_write, mem_read, is_halted}), 0);
        cyc = 0; nir = 0; nrw = 0; wb = 0; nrd = 0; nwr = 0; halted = 0;
      end else if (halted) begin
        chk("halt_sticky", int'(is_halted), 1);
        chk("halt_no_enables",
            int'({pc_update, ir_write, reg_write, mem_write, mem_read}), 0);
      end else begin
        cyc++;
        if (ir_write) nir++;
        if (reg_write) begin nrw++; wb = int'(wb_sel); end
        if (mem_read && i_or_d) nrd++;
        if (mem_write) nwr++;
        if (pc_update || is_halted) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_retire: got pc_update=%0b is_halted=%0b, expected no event",
                     pc_update, is_halted);
          end else begin
            e = sbq.pop_front();
            chk("cycles", cyc, e.cycles);
            chk("halt_flag", int'(is_halted), e.halt);
            chk("ir_write_count", nir, 1);
            chk("reg_write_count", nrw, e.nrw);
            if (e.nrw > 0) chk("wb_sel", wb, e.wb);
            chk("data_read_cycles", nrd, e.nrd);
            chk("write_cycles", nwr, e.nwr);
            if (e.halt != 0) begin
              chk("halt_no_pc_update", int'(pc_update), 0);
              halted = 1;
            end else begin
              chk("pc_source", int'(pc_source), e.pcsrc);
              chk("alu_src_a", int'(alu_src_a), e.asa);
              chk("reg_write_at_retire", int'(reg_write), e.rwret);
            end
          end
          cyc = 0; nir = 0; nrw = 0; wb = 0; nrd = 0; nwr = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge that starts the next fetch.
  task automatic run_instr(input logic [6:0] opc, input bit bc, input bit hc,
                           input int wif, input int wmem, output bit halted);
    exp_t e;
    int   phase = 0;
    int   left  = wif;
    int   k     = 0;
    bit   done  = 0;
    opcode = opc; bcond = bc; halt_cond = hc;
    e = model(opc, bc, hc, wif, wmem);
    sbq.push_back(e);
    halted = (e.halt != 0);
    while (!done) begin
      #1;
      if (mem_read || mem_write) begin
        if (left > 0) begin
          mem_ready = 1'b0;
          left--;
        end else begin
          mem_ready = 1'b1;
          if (phase == 0) begin phase = 1; left = wmem; end
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #2;
      if (pc_update || is_halted) done = 1;
      k++;
      if (!done && k >= 60) begin
        tests++; fails++;
        $display("FAIL instr_timeout: opcode %b gave no retire within %0d cycles", opc, k);
        sbq.delete();
        done = 1;
      end
      @(negedge clk);
    end
    if (!halted) retired++;
  endtask

  task automatic halt_and_reset();
`ifdef MC_PERF_CNT_EN
    logic [31:0] c0;
    c0 = cycle_count;
    chk("instr_count_at_halt", int'(instr_count), retired);
    repeat (3) @(negedge clk);
    chk("cycle_count_frozen", int'(cycle_count), int'(c0));
`else
    repeat (3) @(negedge clk);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    retired = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit h;
    logic [6:0] opc;
    int k;
    bit aborted;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_instr(OP_R,    0, 0, 0, 0, h);
    run_instr(OP_LD,   0, 0, 0, 2, h);
    run_instr(OP_BR,   1, 0, 0, 0, h);
    run_instr(OP_BR,   0, 0, 0, 0, h);
    run_instr(OP_JALR, 0, 0, 0, 0, h);
    run_instr(OP_JAL,  0, 0, 1, 0, h);
    run_instr(OP_ST,   0, 0, 2, 1, h);
    run_instr(OP_SYS,  0, 0, 0, 0, h);
    run_instr(OP_I,    0, 0, 0, 0, h);
    run_instr(OP_SYS,  0, 1, 1, 0, h);
    halt_and_reset();

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 8))
        0: opc = OP_R;    1: opc = OP_I;   2: opc = OP_LD;
        3: opc = OP_ST;   4: opc = OP_BR;  5: opc = OP_JAL;
        6: opc = OP_JALR; 7: opc = OP_SYS;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      run_instr(opc, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), $urandom_range(0, 3), h);
      if (h) halt_and_reset();
    end

    // Store aborted by reset while waiting in MEM_WR.
    opcode = OP_ST; bcond = 1'b0; halt_cond = 1'b0;
    aborted = 0;
    k = 0;
    while (!aborted && k < 20) begin
      #1;
      if (mem_write) begin
        mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mem_write_drops", int'(mem_write), 0);
        chk("abort_no_pc_update", int'(pc_update), 0);
        chk("abort_no_reg_write", int'(reg_write), 0);
        aborted = 1;
      end else begin
        mem_ready = 1'b1;
      end
      k++;
      @(negedge clk);
    end
    if (!aborted) begin
      tests++; fails++;
      $display("FAIL abort_store: got no mem_write within %0d cycles, expected one", k);
      reset = 1'b0;
      sbq.delete();
      @(negedge clk);
    end
`ifdef MC_PERF_CNT_EN
    chk("abort_cycle_count_zero", int'(cycle_count), 0);
    chk("abort_instr_count_zero", int'(instr_count), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    retired = 0;
    run_instr(OP_R, 0, 0, 0, 0, h);
    run_instr(OP_SYS, 0, 1, 0, 0, h);
    halt_and_reset();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
